// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//   Shared definitions for the sequential shift/rotate register:
//     - operation encodings carried on the 3-bit op field
//     - controller state type
//     - helper that derives the default shift-amount field width
//     - helper that classifies an op as one that takes per-clock steps
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    // Operation encodings. Codes 6 and 7 are reserved and behave as a no-op
    // that still returns a completion pulse.
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The amount field is one bit wider than needed to address a bit, so a
    // full-width (or longer) shift can be requested in a single command.
    function automatic int cnt_w_f(input int width);
        return $clog2(width) + 1;
    endfunction

    // True for the ops that walk the word one position per clock.
    function automatic logic is_step_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_seq_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational one-position stepper. WIDTH-generic form of the older
//   8-bit left/right shifter, extended with rotate and arithmetic modes.
//
//   Ports:
//     q_i        current register word
//     op_i       operation code (shift_reg_pkg encodings)
//     sin_i      fill bit for logical shifts
//     q_next_o   word after one step
//     bit_out_o  bit leaving the word on this step
//
//   LOAD and the reserved codes pass the word through untouched; the
//   controller never clocks the stepper result in for those codes anyway.
// -----------------------------------------------------------------------------
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       op_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             bit_out_o
);

    always_comb begin
        q_next_o  = q_i;
        bit_out_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                q_next_o  = {q_i[WIDTH-2:0], sin_i};
                bit_out_o = q_i[WIDTH-1];
            end
            OP_SHR: begin
                q_next_o  = {sin_i, q_i[WIDTH-1:1]};
                bit_out_o = q_i[0];
            end
            OP_ROL: begin
                q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                bit_out_o = q_i[WIDTH-1];
            end
            OP_ROR: begin
                q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
                bit_out_o = q_i[0];
            end
            OP_ASR: begin
                // Sign bit is replicated, so repeated steps saturate to all-sign.
                q_next_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                bit_out_o = q_i[0];
            end
            default: begin
                q_next_o  = q_i;
                bit_out_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// -----------------------------------------------------------------------------
// shift_reg_seq
//   Multi-cycle shift/rotate register with a start/busy/done handshake.
//   Holds a WIDTH-bit word and performs parallel load, logical shift, rotate
//   or arithmetic shift by a programmable amount, one position per clock.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     start  command strobe, only looked at while idle
//     op     operation code (see shift_reg_pkg)
//     amt    number of single-position steps
//     sin    fill bit for SHL/SHR
//     din    parallel load value
//     q      register contents
//     sout   last bit shifted or rotated out
//     busy   operation in progress
//     done   one-cycle completion pulse
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; LOAD / zero-step commands finish here
//   ST_RUN  | stepping once per clock until the step counter reaches 0
//
//   Every output comes straight from a flop; busy is the RUN state bit.
// -----------------------------------------------------------------------------
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic               sin_q,   sin_d;
    logic [WIDTH-1:0]   q_q,     q_d;
    logic               sout_q,  sout_d;
    logic               done_q,  done_d;

    logic [WIDTH-1:0]   step_q;
    logic               step_bit;

    // The stepper always works from the latched command, so op/sin may
    // change freely while a command is running.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i       (q_q),
        .op_i      (op_q),
        .sin_i     (sin_q),
        .q_next_o  (step_q),
        .bit_out_o (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            sin_q   <= 1'b0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sin_q   <= sin_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sin_d   = sin_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    sin_d = sin;
                    if (op == OP_LOAD) begin
                        q_d    = din;
                        done_d = 1'b1;
                    end else if (is_step_op(op) && (amt != '0)) begin
                        cnt_d   = amt;
                        state_d = ST_RUN;
                    end else begin
                        // Zero-step shift or reserved code: acknowledge only.
                        done_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                q_d    = step_q;
                sout_d = step_bit;
                cnt_d  = cnt_q - CNT_W'(1);
                // Leaving on the last step makes done rise exactly as busy falls,
                // and leaves the done cycle idle so a new start is taken there.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;
    import shift_reg_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  op;
    logic [4:0]  amt;
    logic        sin;
    logic [15:0] din;

    logic [7:0]  q8;
    logic [15:0] q16;
    logic [4:0]  q5;
    logic [2:0]  sout_v, busy_v, done_v;

    int errors = 0;
    int checks = 0;
    int sel_cur = 0;

    logic [15:0] cur_q;
    logic        cur_sout, cur_busy, cur_done;

    shift_reg_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .amt(amt[3:0]),
        .sin(sin), .din(din[7:0]), .q(q8), .sout(sout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    shift_reg_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .amt(amt[4:0]),
        .sin(sin), .din(din[15:0]), .q(q16), .sout(sout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    shift_reg_seq #(.WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .amt(amt[3:0]),
        .sin(sin), .din(din[4:0]), .q(q5), .sout(sout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_q = 16'h0;
        case (sel_cur)
            0:       cur_q = {8'h0, q8};
            1:       cur_q = q16;
            default: cur_q = {11'h0, q5};
        endcase
        cur_sout = sout_v[sel_cur];
        cur_busy = busy_v[sel_cur];
        cur_done = done_v[sel_cur];
    end

    // busy and done must never be high together on any instance.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((busy_v & done_v) != 3'b000) begin
                errors++;
                $display("FAIL busy_done_overlap: got %b expected 000", busy_v & done_v);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic int wid(input int s);
        return (s == 0) ? 8 : (s == 1) ? 16 : 5;
    endfunction

    function automatic logic bit_of(input int unsigned v, input int i);
        return ((v >> i) & 32'd1) != 0;
    endfunction

    // Whole-command reference: result computed in closed form from the amount.
    function automatic void model(input int w, input logic [2:0] o, input int n, input logic si,
                                  input logic [15:0] qin, input logic sout_prev,
                                  output logic [15:0] qout, output logic sout, output int cyc);
        int unsigned m, qi, r, fill, k;
        logic sign;
        m    = (32'd1 << w) - 32'd1;
        qi   = {16'h0, qin} & m;
        r    = qi;
        sout = sout_prev;
        cyc  = 0;
        qout = qin;
        if (!(o >= OP_SHL && o <= OP_ASR) || n == 0) return;
        cyc = n;
        case (o)
            OP_SHL: begin
                fill = si ? 32'hFFFF_FFFF : 32'h0;
                if (n >= w) r = fill & m;
                else r = ((qi << n) | (fill & ((32'd1 << n) - 32'd1))) & m;
                sout = (n <= w) ? bit_of(qi, w - n) : si;
            end
            OP_SHR: begin
                fill = si ? 32'hFFFF_FFFF : 32'h0;
                if (n >= w) r = fill & m;
                else r = (qi >> n) | (fill & m & ~(m >> n));
                sout = (n <= w) ? bit_of(qi, n - 1) : si;
            end
            OP_ROL: begin
                k = n % w;
                r = ((qi << k) | (qi >> (w - k))) & m;
                sout = bit_of(r, 0);
            end
            OP_ROR: begin
                k = n % w;
                r = ((qi >> k) | (qi << (w - k))) & m;
                sout = bit_of(r, w - 1);
            end
            default: begin
                sign = bit_of(qi, w - 1);
                fill = sign ? 32'hFFFF_FFFF : 32'h0;
                if (n >= w) r = fill & m;
                else r = (qi >> n) | (fill & m & ~(m >> n));
                sout = (n <= w) ? bit_of(qi, n - 1) : sign;
            end
        endcase
        qout = r[15:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one command on instance s (called #1 after a rising edge) and wait
    // for it to finish; cyc counts busy cycles.
    task automatic run_cmd(input int s, input logic [2:0] o, input logic [4:0] a, input logic si,
                           input logic [15:0] d, output logic [15:0] rq, output logic rs,
                           output int cyc, output logic rd);
        sel_cur = s;
        op = o; amt = a; sin = si; din = d;
        start_v = 3'b000;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
        op  = 3'($urandom);
        amt = 5'($urandom);
        din = 16'($urandom);
        cyc = 0;
        while (cur_busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        rq = cur_q; rs = cur_sout; rd = cur_done;
    endtask

    typedef struct {
        int          sel;
        logic [2:0]  op;
        logic [4:0]  amt;
        logic        sin;
        logic [15:0] pre;
        logic [15:0] exp_q;
        logic        exp_sout;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[15];

    logic [15:0] rq, eq;
    logic        rs, rd, es, seen_done;
    logic [15:0] mq[3];
    logic        ms[3];
    int          cyc, ec;

    initial begin
        tbl[0]  = '{0, OP_SHL, 5'd3,  1'b1, 16'h00A5, 16'h002F, 1'b1, 3};
        tbl[1]  = '{0, OP_ROR, 5'd9,  1'b0, 16'h0081, 16'h00C0, 1'b1, 9};
        tbl[2]  = '{0, OP_ASR, 5'd10, 1'b0, 16'h0080, 16'h00FF, 1'b1, 10};
        tbl[3]  = '{0, OP_SHR, 5'd0,  1'b0, 16'h003C, 16'h003C, 1'b1, 0};
        tbl[4]  = '{0, 3'd7,   5'd5,  1'b1, 16'h005A, 16'h005A, 1'b1, 0};
        tbl[5]  = '{0, OP_SHR, 5'd1,  1'b0, 16'h005A, 16'h002D, 1'b0, 1};
        tbl[6]  = '{0, OP_SHL, 5'd8,  1'b0, 16'h00FF, 16'h0000, 1'b1, 8};
        tbl[7]  = '{0, OP_SHR, 5'd12, 1'b1, 16'h0000, 16'h00FF, 1'b1, 12};
        tbl[8]  = '{0, OP_ROL, 5'd1,  1'b0, 16'h0040, 16'h0080, 1'b0, 1};
        tbl[9]  = '{0, OP_ASR, 5'd3,  1'b0, 16'h007F, 16'h000F, 1'b1, 3};
        tbl[10] = '{0, OP_ROL, 5'd4,  1'b0, 16'h0012, 16'h0021, 1'b1, 4};
        tbl[11] = '{1, OP_SHL, 5'd3,  1'b1, 16'hA5A5, 16'h2D2F, 1'b1, 3};
        tbl[12] = '{1, OP_ROR, 5'd9,  1'b0, 16'h8001, 16'h00C0, 1'b0, 9};
        tbl[13] = '{2, OP_SHL, 5'd3,  1'b1, 16'h0015, 16'h000F, 1'b1, 3};
        tbl[14] = '{2, OP_ROR, 5'd9,  1'b0, 16'h0011, 16'h0003, 1'b0, 9};

        reset = 1'b1; start_v = 3'b000; op = 3'd0; amt = 5'd0; sin = 1'b0; din = 16'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_q8", q8, 0);
        check("rst_q16", q16, 0);
        check("rst_q5", q5, 0);
        check("rst_busy", busy_v, 0);
        check("rst_done", done_v, 0);
        check("rst_sout", sout_v, 0);

        // Asynchronous reset in the middle of a done cycle.
        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h003C, rq, rs, cyc, rd);
        check("pre_rst_load_q", rq, 16'h003C);
        #2 reset = 1'b1;
        #1;
        check("async_rst_q", q8, 0);
        check("async_rst_done", done_v[0], 0);
        check("async_rst_busy", busy_v[0], 0);
        @(posedge clk); #1 reset = 1'b0;

        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h00A5, rq, rs, cyc, rd);
        check("load_q", rq, 16'h00A5);
        check("load_done", rd, 1);
        check("load_cycles", cyc, 0);

        // Table: preload each vector, then run the command back to back.
        foreach (tbl[i]) begin
            run_cmd(tbl[i].sel, OP_LOAD, 5'd0, 1'b0, tbl[i].pre, rq, rs, cyc, rd);
            check("tbl_preload", rq, tbl[i].pre);
            run_cmd(tbl[i].sel, tbl[i].op, tbl[i].amt, tbl[i].sin, 16'hFFFF, rq, rs, cyc, rd);
            check("tbl_q", rq, tbl[i].exp_q);
            check("tbl_sout", rs, tbl[i].exp_sout);
            check("tbl_cycles", cyc, tbl[i].exp_cyc);
            check("tbl_done", rd, 1);
        end

        // SHL by 3 with sin=1 on A5: q after each step edge.
        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h00A5, rq, rs, cyc, rd);
        op = OP_SHL; amt = 5'd3; sin = 1'b1; start_v = 3'b001;
        @(posedge clk); #1 start_v = 3'b000;
        check("shl3_busy0", busy_v[0], 1);
        @(posedge clk); #1 check("shl3_step1", q8, 8'h4B);
        @(posedge clk); #1 check("shl3_step2", q8, 8'h97);
        check("shl3_busy2", busy_v[0], 1);
        @(posedge clk); #1 check("shl3_step3", q8, 8'h2F);
        check("shl3_done", done_v[0], 1);
        check("shl3_sout", sout_v[0], 1);
        @(posedge clk); #1 check("shl3_done_pulse", done_v[0], 0);

        // A start during RUN with another op is dropped and not queued.
        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h000F, rq, rs, cyc, rd);
        op = OP_SHL; amt = 5'd4; sin = 1'b0; start_v = 3'b001;
        @(posedge clk); #1 start_v = 3'b000;
        cyc = 0;
        while (busy_v[0] && cyc < 50) begin
            cyc++;
            if (cyc == 2) begin start_v = 3'b001; op = OP_ROR; amt = 5'd1; end
            else start_v = 3'b000;
            @(posedge clk); #1;
        end
        check("ignore_q", q8, 8'hF0);
        check("ignore_sout", sout_v[0], 0);
        check("ignore_cycles", cyc, 4);
        @(posedge clk); #1;
        check("ignore_not_queued_busy", busy_v[0], 0);
        check("ignore_not_queued_q", q8, 8'hF0);

        // Reset at step 2 of a 5-step SHL: work lost, no done.
        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h000F, rq, rs, cyc, rd);
        op = OP_SHL; amt = 5'd5; sin = 1'b1; start_v = 3'b001;
        @(posedge clk); #1 start_v = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("midrun_rst_q", q8, 0);
        check("midrun_rst_busy", busy_v[0], 0);
        @(posedge clk); #1 reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen_done = seen_done | done_v[0] | busy_v[0];
            @(posedge clk); #1;
        end
        check("midrun_rst_no_done", seen_done, 0);
        run_cmd(0, OP_LOAD, 5'd0, 1'b0, 16'h005A, rq, rs, cyc, rd);
        run_cmd(0, OP_ROL, 5'd1, 1'b0, 16'h0000, rq, rs, cyc, rd);
        check("after_rst_q", rq, 16'h00B4);
        check("after_rst_sout", rs, 0);
        check("after_rst_done", rd, 1);

        // Random back-to-back commands against the closed-form model.
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            mq[s] = 16'h0; ms[s] = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 60; i++) begin
                logic [2:0]  o;
                logic [4:0]  a;
                logic        si;
                logic [15:0] d;
                int          w;
                w  = wid(s);
                o  = 3'($urandom_range(0, 7));
                a  = (s == 1) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
                si = 1'($urandom);
                d  = 16'($urandom) & 16'((32'd1 << w) - 32'd1);
                if (o == OP_LOAD) begin
                    eq = d; es = ms[s]; ec = 0;
                end else begin
                    model(w, o, int'(a), si, mq[s], ms[s], eq, es, ec);
                end
                run_cmd(s, o, a, si, d, rq, rs, cyc, rd);
                check("rnd_q", rq, eq);
                check("rnd_sout", rs, es);
                check("rnd_cycles", cyc, ec);
                check("rnd_done", rd, 1);
                mq[s] = eq; ms[s] = es;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised sequential shift/rotate register, the clocked successor to the team's combinational 8-bit one-position left/right shifter. It holds a WIDTH-bit word and executes commanded operations: parallel load, logical shift, rotate or arithmetic shift by a programmable amount, one bit position per clock. It uses a start/busy/done handshake, so it can sit behind the register file or an ALU sequencer as a small-area multi-cycle shifter.

## Interface
Parameters:
- WIDTH, 8, data word width (≥2)
- CNT_W, $clog2(WIDTH)+1, width of shift-amount field (amounts 0..2^CNT_W-1)

Ports (one clock; reset is asynchronous and active-high):
- clk    in   1        rising-edge clock
- reset  in   1        asynchronous, active-high reset
- start  in   1        command strobe, sampled only when busy=0
- op     in   3        0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6/7 reserved
- amt    in   CNT_W    number of single-position steps
- sin    in   1        fill bit for SHL (into bit 0) and SHR (into bit WIDTH-1)
- din    in   WIDTH    parallel load value
- q      out  WIDTH    register contents
- sout   out  1        last bit shifted or rotated out
- busy   out  1        operation in progress
- done   out  1        one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN.
- IDLE, start=1 at an edge: latch op, amt and sin.
  - LOAD: q<=din. sout unchanged. Stay IDLE. done=1 for the next cycle.
  - Shift/rotate op with amt=0, or reserved op: no change to q. Stay IDLE. done=1 next cycle.
  - Shift/rotate op with amt=N>0: counter<=N, go to RUN, busy=1.
- RUN, each edge: apply one step to q and decrement the counter. After the step that takes the counter to 0: go to IDLE, busy=0, done=1 for one cycle.
- Step definitions, with W=WIDTH:
  - SHL: q<={q[W-2:0],sin}, sout<=q[W-1]
  - SHR: q<={sin,q[W-1:1]}, sout<=q[0]
  - ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1]
  - ROR: q<={q[0],q[W-1:1]}, sout<=q[0]
  - ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0]
- amt ≥ WIDTH is legal and runs exactly amt steps. Rotates wrap naturally; SHL/SHR saturate to all-sin; ASR saturates to all-sign.
- start while busy=1 is ignored. The command is not queued.
- din, amt and op are don't-care except at an accepting edge.

## Timing
- Reset values: q=0, sout=0, busy=0, done=0, FSM=IDLE, counter=0. Reset is asynchronous and takes effect mid-RUN too; the operation is lost and no done is issued.
- LOAD and amt=0 latency: done high in the cycle after the accepting edge. q already reflects the load in that cycle.
- Shift latency N: busy high for N cycles after the accepting edge. q is updated at each of those N edges. done is asserted with busy falling.
- done and busy are never high together. done is a single-cycle pulse.
- Back-to-back: start may be high in the done cycle and is accepted at that edge (zero bubble).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package shift_reg_pkg holds:
  - op encoding constants (OP_LOAD..OP_ASR)
  - FSM state typedef
  - CNT_W helper function
- Sub-module shift_step: combinational one-position stepper taking (q, op, sin) and returning (q_next, bit_out). It is the WIDTH-generic form of the existing 8-bit shifter, with rotate and arithmetic modes added. The top level holds only the FSM, counter and registers.

## Test plan
- Reset then LOAD: assert reset mid-cycle -> q=0, busy=0, done=0 immediately. Then start, op=LOAD, din=8'hA5 -> next cycle q=8'hA5, done=1, busy=0.
- SHL by 3, sin=1, q=8'hA5 -> busy for 3 cycles with q sequence 4B, 97, 2F; then done=1, q=8'h2F, sout=1.
- ROR by 9 on 8'h81 (WIDTH=8) -> 9 busy cycles, final q=8'hC0, sout=1. ASR by 10 on 8'h80 -> q=8'hFF.
- amt=0 SHR and op=7 -> q unchanged, done after 1 cycle, busy never asserted.
- start during RUN with a different op is ignored (result matches the first command). start in the done cycle is accepted and completes correctly with no bubble.
- Reset asserted at step 2 of a 5-step SHL -> q=0, busy=0, no done pulse. A subsequent command completes normally. Repeat the SHL/ROR cases with WIDTH=16 and WIDTH=5.
